// File: rtl/dc_write_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Package     : dc_write_buffer_pkg
// Description : Shared constants for the data-cache posted write buffer:
//               default geometry, pointer width helper, FSM state encoding
//               and the word-address slice used for hit comparison.
// Revision    : 1.0 - initial release
// ============================================================================
package dc_write_buffer_pkg;

    localparam int c_DEPTH_DEFAULT = 4;
    localparam int c_AW_DEFAULT    = 32;
    localparam int c_DW_DEFAULT    = 32;

    // Byte-offset bits below this index are ignored when comparing words
    localparam int c_WORD_LSB = 2;

    // Drain/read FSM encoding
    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RD   = 2'd1;
    localparam logic [1:0] c_ST_WR   = 2'd2;

    localparam int c_PTR_W_DEFAULT = $clog2(c_DEPTH_DEFAULT);

    // Pointer width for a power-of-two depth (at least one bit)
    function automatic int ptr_width(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dc_write_buffer_if.sv
`default_nettype none
// ============================================================================
// Interface   : dc_write_buffer_if
// Description : Cache-side and arbiter-side signals of the posted write
//               buffer. The buffer uses the slave view; the cache/arbiter
//               environment uses the master view.
// Revision    : 1.0 - initial release
// ============================================================================
interface dc_write_buffer_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    // cache side
    logic          cache_write;
    logic          cache_read;
    logic [AW-1:0] cache_addr;
    logic [DW-1:0] cache_wdata;
    logic          cache_accept;
    logic          cache_ready;
    logic [DW-1:0] cache_rdata;
    logic          wb_empty;

    // arbiter / memory side
    logic          mem_read_req;
    logic          mem_write_req;
    logic          mem_grant;
    logic          mem_ready;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  cache_write, cache_read, cache_addr, cache_wdata,
        input  mem_grant, mem_ready, mem_rdata,
        output cache_accept, cache_ready, cache_rdata, wb_empty,
        output mem_read_req, mem_write_req, mem_addr, mem_wdata
    );

    modport master (
        output cache_write, cache_read, cache_addr, cache_wdata,
        output mem_grant, mem_ready, mem_rdata,
        input  cache_accept, cache_ready, cache_rdata, wb_empty,
        input  mem_read_req, mem_write_req, mem_addr, mem_wdata
    );

endinterface
`default_nettype wire

// File: rtl/dc_write_buffer_wb_fifo.sv
`default_nettype none
// ============================================================================
// Module      : dc_write_buffer_wb_fifo
// Description : Circular store of {address, data} write entries with
//               per-entry valid bits and a parallel word-address compare
//               against the current cache address.
// Revision    : 1.0 - initial release
// ============================================================================
module dc_write_buffer_wb_fifo
    import dc_write_buffer_pkg::*;
#(
    parameter  int DEPTH = c_DEPTH_DEFAULT,
    parameter  int AW    = c_AW_DEFAULT,
    parameter  int DW    = c_DW_DEFAULT,
    localparam int PW    = ptr_width(DEPTH)
) (
    input  wire logic          clk,
    input  wire logic          rst,
    input  wire logic          i_push,
    input  wire logic [AW-1:0] i_addr,
    input  wire logic [DW-1:0] i_data,
    input  wire logic          i_pop,
    input  wire logic [AW-1:0] i_cmp_addr,
    output logic               o_full,
    output logic               o_empty,
    output logic [PW:0]        o_count,
    output logic [AW-1:0]      o_head_addr,
    output logic [DW-1:0]      o_head_data,
    output logic               o_hit
);

    localparam logic [PW-1:0] c_PTR_ONE = PW'(1);
    localparam logic [PW:0]   c_FULL    = (PW+1)'(DEPTH);

    logic [AW-1:0]    r_addr [DEPTH];
    logic [DW-1:0]    r_data [DEPTH];
    logic [DEPTH-1:0] r_valid;
    logic [PW-1:0]    r_head;
    logic [PW-1:0]    r_tail;
    logic [PW:0]      r_count;
    logic             r_empty;

    logic             w_push;
    logic             w_pop;
    logic [PW:0]      w_count_next;
    logic [DEPTH-1:0] w_match;

    // Guard push/pop against full/empty using the count at cycle start
    assign w_push = i_push && (r_count != c_FULL);
    assign w_pop  = i_pop  && (r_count != '0);

    // Next occupancy; a simultaneous push and pop leaves it unchanged
    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + 1'b1;
            2'b01:   w_count_next = r_count - 1'b1;
            default: w_count_next = r_count;
        endcase
    end

    // Entry payload storage, written at the tail
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr[r_tail] <= i_addr;
            r_data[r_tail] <= i_data;
        end
    end

    // Pointers, occupancy, valid bits and the registered empty flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_valid <= '0;
            r_empty <= 1'b1;
        end else begin
            if (w_push) begin
                r_tail          <= r_tail + c_PTR_ONE;
                r_valid[r_tail] <= 1'b1;
            end
            if (w_pop) begin
                r_head          <= r_head + c_PTR_ONE;
                r_valid[r_head] <= 1'b0;
            end
            r_count <= w_count_next;
            r_empty <= (w_count_next == '0);
        end
    end

    // Word-granular compare of every live entry against the cache address
    for (genvar i = 0; i < DEPTH; i++) begin : g_cmp
        assign w_match[i] = r_valid[i] &&
            (r_addr[i][AW-1:c_WORD_LSB] == i_cmp_addr[AW-1:c_WORD_LSB]);
    end

    assign o_hit       = |w_match;
    assign o_full      = (r_count == c_FULL);
    assign o_empty     = r_empty;
    assign o_count     = r_count;
    assign o_head_addr = r_addr[r_head];
    assign o_head_data = r_data[r_head];

endmodule
`default_nettype wire

// File: rtl/dc_write_buffer.sv
`default_nettype none
// ============================================================================
// Module      : dc_write_buffer
// Description : Posted write buffer between the write-back data cache and
//               the memory arbiter. Writes are absorbed and drained in
//               order; read misses bypass pending drains, read hits wait
//               until every matching entry has drained.
// Revision    : 1.0 - initial release
// ============================================================================
module dc_write_buffer
    import dc_write_buffer_pkg::*;
#(
    parameter int DEPTH = c_DEPTH_DEFAULT,
    parameter int AW    = c_AW_DEFAULT,
    parameter int DW    = c_DW_DEFAULT
) (
    input  wire logic        clk,
    input  wire logic        rst,
    dc_write_buffer_if.slave bus
);

    localparam int PW = ptr_width(DEPTH);

    logic [1:0]    r_state;
    logic          r_mem_read_req;
    logic          r_mem_write_req;
    logic [AW-1:0] r_mem_addr;
    logic [DW-1:0] r_mem_wdata;
    logic          r_cache_ready;
    logic [DW-1:0] r_cache_rdata;

    logic          w_enq;
    logic          w_deq;
    logic          w_full;
    logic          w_empty;
    logic          w_hit;
    logic [PW:0]   w_count;
    logic [AW-1:0] w_head_addr;
    logic [DW-1:0] w_head_data;
    logic          w_mem_done;

    // A pending read blocks new writes so the read never sees a younger write
    assign w_enq      = bus.cache_write && !bus.cache_read && !w_full && !rst;
    assign w_mem_done = bus.mem_grant && bus.mem_ready;
    assign w_deq      = (r_state == c_ST_WR) && w_mem_done;

    dc_write_buffer_wb_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_enq),
        .i_addr      (bus.cache_addr),
        .i_data      (bus.cache_wdata),
        .i_pop       (w_deq),
        .i_cmp_addr  (bus.cache_addr),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_count     (w_count),
        .o_head_addr (w_head_addr),
        .o_head_data (w_head_data),
        .o_hit       (w_hit)
    );

    // Arbiter handshake FSM: read misses first, otherwise drain the head
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= c_ST_IDLE;
            r_mem_read_req  <= 1'b0;
            r_mem_write_req <= 1'b0;
            r_mem_addr      <= '0;
            r_mem_wdata     <= '0;
            r_cache_ready   <= 1'b0;
            r_cache_rdata   <= '0;
        end else begin
            r_cache_ready <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    // The cache still holds cache_read in its ready cycle;
                    // ignore it then so the read is not issued twice.
                    if (bus.cache_read && !w_hit && !r_cache_ready) begin
                        r_state        <= c_ST_RD;
                        r_mem_read_req <= 1'b1;
                        r_mem_addr     <= bus.cache_addr;
                    end else if (w_count != '0) begin
                        r_state         <= c_ST_WR;
                        r_mem_write_req <= 1'b1;
                        r_mem_addr      <= w_head_addr;
                        r_mem_wdata     <= w_head_data;
                    end
                end
                c_ST_RD: begin
                    if (w_mem_done) begin
                        r_state        <= c_ST_IDLE;
                        r_mem_read_req <= 1'b0;
                        r_cache_rdata  <= bus.mem_rdata;
                        r_cache_ready  <= 1'b1;
                    end
                end
                c_ST_WR: begin
                    if (w_mem_done) begin
                        r_state         <= c_ST_IDLE;
                        r_mem_write_req <= 1'b0;
                    end
                end
                default: begin
                    r_state         <= c_ST_IDLE;
                    r_mem_read_req  <= 1'b0;
                    r_mem_write_req <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cache_accept  = w_enq;
    assign bus.cache_ready   = r_cache_ready;
    assign bus.cache_rdata   = r_cache_rdata;
    assign bus.wb_empty      = w_empty;
    assign bus.mem_read_req  = r_mem_read_req;
    assign bus.mem_write_req = r_mem_write_req;
    assign bus.mem_addr      = r_mem_addr;
    assign bus.mem_wdata     = r_mem_wdata;

endmodule
`default_nettype wire

// File: tb/tb_dc_write_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_dc_write_buffer
// Description : Self-checking bench for dc_write_buffer. A queue-based
//               model of buffered writes, a flat memory image and an
//               arbiter/memory responder with programmable latency.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dc_write_buffer;

    localparam int DEPTH = 4;
    localparam int AW    = 32;
    localparam int DW    = 32;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    dc_write_buffer_if #(.AW(AW), .DW(DW)) ifc ();

    dc_write_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    int          vectors     = 0;
    int          miscompares = 0;
    logic [31:0] mem     [1024];
    logic [31:0] ref_mem [1024];
    wr_t         q[$];
    int          drains    = 0;
    int          rd_drains = 0;
    bit          prev_rd_hs = 0;
    bit          got_acc, got_rdy;
    logic [31:0] rdy_data;
    bit          gnt_en = 0;
    int          lat    = 0;
    int          wcnt   = 0;

    function automatic int widx(input logic [31:0] a);
        return int'(a[11:2]);
    endfunction

    function automatic logic [31:0] dflt(input int i);
        return 32'hC0DE_0000 ^ 32'(i * 40503);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: check mid-cycle behaviour, advance, update model and responder
    task automatic tick();
        bit exp_acc, hs_wr, hs_rd, hitq, rst_was;
        @(negedge clk);
        rst_was = rst;
        exp_acc = !rst && ifc.cache_write && !ifc.cache_read && (q.size() < DEPTH);
        chk("accept", ifc.cache_accept, exp_acc);
        chk("ready_pulse", ifc.cache_ready, prev_rd_hs);
        chk("req_excl", ifc.mem_read_req & ifc.mem_write_req, 0);
        chk("wreq_no_data", ifc.mem_write_req && (q.size() == 0), 0);
        hs_wr = !rst && ifc.mem_grant && ifc.mem_ready && ifc.mem_write_req;
        hs_rd = !rst && ifc.mem_grant && ifc.mem_ready && ifc.mem_read_req;
        if (hs_wr) begin
            if (q.size() == 0) begin
                chk("wr_spurious", 1, 0);
            end else begin
                chk("wr_addr", ifc.mem_addr, q[0].a);
                chk("wr_data", ifc.mem_wdata, q[0].d);
                void'(q.pop_front());
            end
            mem[widx(ifc.mem_addr)] = ifc.mem_wdata;
            drains++;
        end
        if (hs_rd) begin
            hitq = 0;
            foreach (q[i]) if (q[i].a[31:2] == ifc.mem_addr[31:2]) hitq = 1;
            chk("rd_after_hit_drain", hitq, 0);
            chk("rd_addr", ifc.mem_addr, ifc.cache_addr);
            rd_drains = drains;
        end
        if (exp_acc) begin
            q.push_back('{ifc.cache_addr, ifc.cache_wdata});
            ref_mem[widx(ifc.cache_addr)] = ifc.cache_wdata;
            got_acc = 1;
        end
        if (ifc.cache_ready === 1'b1) begin
            got_rdy  = 1;
            rdy_data = ifc.cache_rdata;
        end
        @(posedge clk);
        #1;
        if (rst_was) begin
            q.delete();
            prev_rd_hs = 0;
            ref_mem    = mem;
        end else begin
            prev_rd_hs = hs_rd;
        end
        chk("wb_empty", ifc.wb_empty, q.size() == 0);
        // arbiter + memory responder for the coming cycle
        if (!rst && (ifc.mem_read_req || ifc.mem_write_req) && gnt_en) begin
            ifc.mem_grant = 1'b1;
            if (wcnt >= lat) begin
                ifc.mem_ready = 1'b1;
                ifc.mem_rdata = ifc.mem_read_req ? mem[widx(ifc.mem_addr)] : $urandom;
            end else begin
                ifc.mem_ready = 1'b0;
                ifc.mem_rdata = $urandom;
                wcnt++;
            end
        end else begin
            ifc.mem_grant = 1'b0;
            ifc.mem_ready = 1'b0;
            ifc.mem_rdata = $urandom;
            if (rst || !(ifc.mem_read_req || ifc.mem_write_req)) wcnt = 0;
        end
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d);
        ifc.cache_write = 1'b1;
        ifc.cache_addr  = a;
        ifc.cache_wdata = d;
        got_acc = 0;
        for (int n = 0; n < 200 && !got_acc; n++) tick();
        chk("wr_timeout", got_acc, 1);
        ifc.cache_write = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] a);
        logic [31:0] exp;
        exp = ref_mem[widx(a)];
        ifc.cache_read = 1'b1;
        ifc.cache_addr = a;
        got_rdy = 0;
        for (int n = 0; n < 300 && !got_rdy; n++) tick();
        chk("rd_timeout", got_rdy, 1);
        chk("rdata", rdy_data, exp);
        ifc.cache_read = 1'b0;
    endtask

    task automatic wait_empty();
        int n;
        n = 0;
        while (!(ifc.wb_empty === 1'b1 && q.size() == 0) && n < 300) begin
            tick();
            n++;
        end
        chk("drain_timeout", n < 300, 1);
    endtask

    initial begin
        int base;
        for (int i = 0; i < 1024; i++) mem[i] = dflt(i);
        mem[widx(32'h300)] = 32'h0000_DEAD;
        ref_mem = mem;
        rst = 1'b1;
        ifc.cache_write = 1'b0;
        ifc.cache_read  = 1'b0;
        ifc.cache_addr  = '0;
        ifc.cache_wdata = '0;
        ifc.mem_grant   = 1'b0;
        ifc.mem_ready   = 1'b0;
        ifc.mem_rdata   = '0;

        // reset state, including accept suppressed while in reset
        repeat (2) @(posedge clk);
        #1;
        ifc.cache_write = 1'b1;
        #1;
        chk("rst_accept", ifc.cache_accept, 0);
        @(posedge clk);
        #1;
        ifc.cache_write = 1'b0;
        chk("rst_ready", ifc.cache_ready, 0);
        chk("rst_rdata", ifc.cache_rdata, 0);
        chk("rst_empty", ifc.wb_empty, 1);
        chk("rst_rreq", ifc.mem_read_req, 0);
        chk("rst_wreq", ifc.mem_write_req, 0);
        chk("rst_maddr", ifc.mem_addr, 0);
        chk("rst_mwdata", ifc.mem_wdata, 0);
        rst = 1'b0;

        // fill with grant withheld; fifth write must stall
        gnt_en = 0;
        for (int i = 0; i < 4; i++) do_write(32'h100 + 32'(4 * i), 32'hA0 + 32'(i));
        ifc.cache_write = 1'b1;
        ifc.cache_addr  = 32'h110;
        ifc.cache_wdata = 32'hA4;
        got_acc = 0;
        repeat (5) tick();
        chk("full_no_accept", got_acc, 0);
        chk("full_not_empty", ifc.wb_empty, 0);
        chk("head_wreq", ifc.mem_write_req, 1);
        chk("head_addr", ifc.mem_addr, 32'h100);
        chk("head_data", ifc.mem_wdata, 32'hA0);

        // release grant with latency 2; the held write gets in once space frees
        base = drains;
        gnt_en = 1;
        lat = 2;
        for (int n = 0; n < 100 && !got_acc; n++) tick();
        chk("fifth_accept", got_acc, 1);
        ifc.cache_write = 1'b0;
        wait_empty();
        chk("drain_count", drains - base, 5);

        // read miss overtakes the second buffered write
        gnt_en = 0;
        do_write(32'h200, 32'h1);
        do_write(32'h204, 32'h2);
        gnt_en = 1;
        base = drains;
        do_read(32'h300);
        chk("miss_drains_before", rd_drains - base, 1);
        chk("miss_rdata", rdy_data, 32'hDEAD);
        wait_empty();

        // read hit: both writes drain before the read
        gnt_en = 0;
        do_write(32'h200, 32'h11);
        do_write(32'h204, 32'h22);
        gnt_en = 1;
        base = drains;
        do_read(32'h204);
        chk("hit_drains_before", rd_drains - base, 2);
        chk("hit_rdata", rdy_data, 32'h22);
        wait_empty();

        // full buffer with zero-latency drains under 10 sustained writes
        gnt_en = 0;
        for (int i = 0; i < 4; i++) do_write(32'h500 + 32'(4 * i), 32'hB0 + 32'(i));
        gnt_en = 1;
        lat = 0;
        for (int i = 0; i < 10; i++) do_write(32'h600 + 32'(4 * i), 32'hC0 + 32'(i));
        wait_empty();
        do_read(32'h624);

        // reset during a granted write drain
        lat = 6;
        do_write(32'h400, 32'h77);
        repeat (2) tick();
        chk("pre_rst_wreq", ifc.mem_write_req, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_rreq", ifc.mem_read_req, 0);
        chk("mid_rst_wreq", ifc.mem_write_req, 0);
        chk("mid_rst_empty", ifc.wb_empty, 1);
        lat = 1;
        do_write(32'h404, 32'h88);
        wait_empty();
        do_read(32'h400);
        do_read(32'h404);

        // randomized mix against the model
        for (int k = 0; k < 60; k++) begin
            int op;
            logic [31:0] a;
            op  = $urandom_range(0, 3);
            a   = 32'h100 + 32'(4 * $urandom_range(0, 15));
            lat = $urandom_range(0, 3);
            if (op <= 1) begin
                gnt_en = (q.size() == DEPTH) ? 1 : bit'($urandom_range(0, 1));
                do_write(a, $urandom);
            end else if (op == 2) begin
                gnt_en = 1;
                do_read(a);
            end else begin
                gnt_en = bit'($urandom_range(0, 1));
                repeat ($urandom_range(1, 4)) tick();
            end
        end
        gnt_en = 1;
        wait_empty();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
